// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: direct-mapped one-word-line I-cache feeding a
// circular instruction queue, with flush/redirect and miss-abort handling.
module inst_fetch_unit #(
  parameter int ADDR_W       = 32,
  parameter int INST_W       = 32,
  parameter int ICACHE_LINES = 64,
  parameter int IQ_DEPTH     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_done_i,
  input  logic [INST_W-1:0] mem_data_i,
  input  logic              deq_i,
  output logic              iq_valid_o,
  output logic [ADDR_W-1:0] iq_pc_o,
  output logic [INST_W-1:0] iq_inst_o,
  output logic              iq_full_o
);

  localparam int IDX   = $clog2(ICACHE_LINES);
  localparam int TAG_W = ADDR_W - IDX - 2;
  localparam int PW    = $clog2(IQ_DEPTH);
  localparam int CW    = $clog2(IQ_DEPTH + 1);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    ABORT
  } state_t;

  state_t state;

  logic [ICACHE_LINES-1:0] line_valid;
  logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
  logic [INST_W-1:0]       data_mem [ICACHE_LINES];

  logic [ADDR_W-1:0] q_pc   [IQ_DEPTH];
  logic [INST_W-1:0] q_inst [IQ_DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic [ADDR_W-1:0] fetch_pc;

  logic [IDX-1:0]    idx;
  logic [TAG_W-1:0]  tag;
  logic [IDX-1:0]    fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              full;
  logic              fill;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_pc;
  logic [INST_W-1:0] push_inst;

  assign idx      = fetch_pc[IDX+1:2];
  assign tag      = fetch_pc[ADDR_W-1:IDX+2];
  assign fill_idx = mem_addr_o[IDX+1:2];
  assign fill_tag = mem_addr_o[ADDR_W-1:IDX+2];
  assign hit      = line_valid[idx] && (tag_mem[idx] == tag);
  assign full     = (count == CW'(IQ_DEPTH));
  assign fill     = (state != IDLE) && mem_done_i;
  assign pop      = deq_i && (count != '0) && !flush_i;

  always_comb begin
    push      = 1'b0;
    push_pc   = fetch_pc;
    push_inst = data_mem[idx];
    if (!flush_i) begin
      case (state)
        IDLE: push = hit && !full;
        MISS: begin
          push      = mem_done_i;
          push_pc   = mem_addr_o;
          push_inst = mem_data_i;
        end
        default: push = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC & ALIGN;
      line_valid <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else if (rdy) begin
      if (fill) line_valid[fill_idx] <= 1'b1;
      if (flush_i) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        fetch_pc <= flush_pc_i & ALIGN;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (push) fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      case (state)
        IDLE: begin
          if (!flush_i && !hit && !full) begin
            state      <= MISS;
            mem_req_o  <= 1'b1;
            mem_addr_o <= fetch_pc;
          end
        end
        MISS: begin
          if (mem_done_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
          end else if (flush_i) begin
            state <= ABORT;
          end
        end
        ABORT: begin
          if (mem_done_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array storage carries no reset; line_valid and count gate every read.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (fill) begin
        tag_mem[fill_idx]  <= fill_tag;
        data_mem[fill_idx] <= mem_data_i;
      end
      if (push) begin
        q_pc[tail]   <= push_pc;
        q_inst[tail] <= push_inst;
      end
    end
  end

  assign iq_valid_o = (count != '0);
  assign iq_full_o  = full;
  assign iq_pc_o    = q_pc[head];
  assign iq_inst_o  = q_inst[head];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: cold start, hit stream, queue full,
// flush during miss, flush with completion, set conflict and rdy stall.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_done_i;
  logic [31:0] mem_data_i;
  logic        deq_i;
  logic        iq_valid_o;
  logic [31:0] iq_pc_o;
  logic [31:0] iq_inst_o;
  logic        iq_full_o;

  int n_checks;
  int n_fail;

  inst_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_done_i (mem_done_i),
    .mem_data_i (mem_data_i),
    .deq_i      (deq_i),
    .iq_valid_o (iq_valid_o),
    .iq_pc_o    (iq_pc_o),
    .iq_inst_o  (iq_inst_o),
    .iq_full_o  (iq_full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (32'hA000_0000 | a);
  endfunction

  // Complete the outstanding request with a one-cycle done pulse.
  task automatic complete(input logic [31:0] a);
    mem_done_i = 1'b1;
    mem_data_i = mdata(a);
    step();
    mem_done_i = 1'b0;
    mem_data_i = '0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    rdy        = 1'b1;
    flush_i    = 1'b0;
    flush_pc_i = '0;
    mem_done_i = 1'b0;
    mem_data_i = '0;
    deq_i      = 1'b0;

    step();
    step();
    chk("rst_valid", 32'(iq_valid_o), 32'd0);
    chk("rst_full", 32'(iq_full_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);

    // Cold start
    rst = 1'b0;
    step();
    chk("cold_req", 32'(mem_req_o), 32'd1);
    chk("cold_addr", mem_addr_o, 32'h0);
    complete(32'h0);
    chk("cold_valid", 32'(iq_valid_o), 32'd1);
    chk("cold_pc", iq_pc_o, 32'h0);
    chk("cold_inst", iq_inst_o, 32'h0050_0093);
    chk("cold_req_drop", 32'(mem_req_o), 32'd0);
    step();
    chk("cold_next_req", 32'(mem_req_o), 32'd1);
    chk("cold_next_addr", mem_addr_o, 32'h4);

    // Fill 0x4..0x1C; the queue reaches 8 entries
    for (int a = 4; a <= 32'h1C; a += 4) begin
      chk("fill_addr", mem_addr_o, 32'(a));
      complete(32'(a));
      step();
    end
    chk("fill_full", 32'(iq_full_o), 32'd1);
    chk("fill_stall_req", 32'(mem_req_o), 32'd0);
    chk("fill_head", iq_pc_o, 32'h0);

    // Hit stream
    flush_i    = 1'b1;
    flush_pc_i = 32'h0;
    deq_i      = 1'b1;
    step();
    flush_i = 1'b0;
    chk("hs_flush_empty", 32'(iq_valid_o), 32'd0);
    step();
    chk("hs_inst0", iq_inst_o, 32'h0050_0093);
    for (int i = 0; i < 8; i++) begin
      chk("hs_valid", 32'(iq_valid_o), 32'd1);
      chk("hs_pc", iq_pc_o, 32'(4 * i));
      chk("hs_req", 32'(mem_req_o), 32'd0);
      step();
    end
    deq_i = 1'b0;
    chk("hs_miss_req", 32'(mem_req_o), 32'd1);
    chk("hs_miss_addr", mem_addr_o, 32'h20);

    // Flush during the 0x20 miss: ABORT, then fill without push
    flush_i    = 1'b1;
    flush_pc_i = 32'h0;
    step();
    flush_i = 1'b0;
    chk("ab_req_held", 32'(mem_req_o), 32'd1);
    chk("ab_addr_held", mem_addr_o, 32'h20);
    chk("ab_empty", 32'(iq_valid_o), 32'd0);
    complete(32'h20);
    chk("ab_req_drop", 32'(mem_req_o), 32'd0);
    chk("ab_no_push", 32'(iq_valid_o), 32'd0);

    // Queue full on hits
    repeat (9) step();
    chk("qf_full", 32'(iq_full_o), 32'd1);
    chk("qf_head", iq_pc_o, 32'h0);
    chk("qf_req", 32'(mem_req_o), 32'd0);
    deq_i = 1'b1;
    step();
    deq_i = 1'b0;
    chk("qf_pop_notfull", 32'(iq_full_o), 32'd0);
    chk("qf_pop_head", iq_pc_o, 32'h4);
    step();
    chk("qf_refull", 32'(iq_full_o), 32'd1);
    chk("qf_refill_req", 32'(mem_req_o), 32'd0);
    step();
    chk("qf_hold", 32'(iq_full_o), 32'd1);

    // Flush mid-miss on 0x40, redirect to 0x100
    flush_i    = 1'b1;
    flush_pc_i = 32'h40;
    step();
    flush_i = 1'b0;
    chk("fm_empty", 32'(iq_valid_o), 32'd0);
    step();
    chk("fm_req", 32'(mem_req_o), 32'd1);
    chk("fm_addr", mem_addr_o, 32'h40);
    step();
    flush_i    = 1'b1;
    flush_pc_i = 32'h100;
    step();
    flush_i = 1'b0;
    chk("fm_abort_req", 32'(mem_req_o), 32'd1);
    chk("fm_abort_addr", mem_addr_o, 32'h40);
    step();
    step();
    complete(32'h40);
    chk("fm_done_req", 32'(mem_req_o), 32'd0);
    chk("fm_not_queued", 32'(iq_valid_o), 32'd0);
    step();
    chk("fm_next_req", 32'(mem_req_o), 32'd1);
    chk("fm_next_addr", mem_addr_o, 32'h100);

    // rdy=0 for 3 cycles mid-MISS; a done pulse there is ignored
    rdy = 1'b0;
    step();
    mem_done_i = 1'b1;
    mem_data_i = 32'hBAD0_0BAD;
    step();
    mem_done_i = 1'b0;
    step();
    chk("rdy_req", 32'(mem_req_o), 32'd1);
    chk("rdy_addr", mem_addr_o, 32'h100);
    chk("rdy_count", 32'(iq_valid_o), 32'd0);
    rdy = 1'b1;
    step();
    chk("rdy_resume_req", 32'(mem_req_o), 32'd1);
    complete(32'h100);
    chk("c_valid", 32'(iq_valid_o), 32'd1);
    chk("c_pc", iq_pc_o, 32'h100);
    chk("c_inst", iq_inst_o, 32'hA000_0100);
    step();
    chk("c_next_addr", mem_addr_o, 32'h104);

    // Flush coincident with done in MISS
    flush_i    = 1'b1;
    flush_pc_i = 32'h40;
    mem_done_i = 1'b1;
    mem_data_i = mdata(32'h104);
    step();
    flush_i    = 1'b0;
    mem_done_i = 1'b0;
    chk("fd_req", 32'(mem_req_o), 32'd0);
    chk("fd_no_push", 32'(iq_valid_o), 32'd0);
    step();
    chk("fd_hit_valid", 32'(iq_valid_o), 32'd1);
    chk("fd_hit_pc", iq_pc_o, 32'h40);
    chk("fd_hit_inst", iq_inst_o, 32'hA000_0040);
    chk("fd_hit_req", 32'(mem_req_o), 32'd0);

    // Conflict: 0x100 evicted 0x0, then 0x0 evicts 0x100
    flush_i    = 1'b1;
    flush_pc_i = 32'h0;
    step();
    flush_i = 1'b0;
    step();
    chk("cf_req0", 32'(mem_req_o), 32'd1);
    chk("cf_addr0", mem_addr_o, 32'h0);
    complete(32'h0);
    chk("cf_pc0", iq_pc_o, 32'h0);
    flush_i    = 1'b1;
    flush_pc_i = 32'h100;
    step();
    flush_i = 1'b0;
    step();
    chk("cf_req100", 32'(mem_req_o), 32'd1);
    chk("cf_addr100", mem_addr_o, 32'h100);
    complete(32'h100);
    chk("cf_pc100", iq_pc_o, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch unit with a parametrised direct-mapped I-cache and an instruction queue. It sits between the PC/branch logic and the memory controller instruction port, and feeds the decode stage through a FIFO with a valid/dequeue handshake. It adds caching, buffering, flush/redirect and miss-abort handling, none of which the single-shot combinational fetch stage has.

Parameters:
ADDR_W, 32, address and PC width
INST_W, 32, instruction width
ICACHE_LINES, 64, number of one-word cache lines; power of 2, at least 2
IQ_DEPTH, 8, instruction queue entries; power of 2, at least 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; when 0, all state is frozen
flush_i  in  1  redirect request (branch mispredict or jump)
flush_pc_i  in  ADDR_W  new fetch PC, valid when flush_i=1
mem_req_o  out  1  memory read request, registered
mem_addr_o  out  ADDR_W  word-aligned read address, registered
mem_done_i  in  1  one-cycle pulse: mem_data_i valid, request complete
mem_data_i  in  INST_W  returned instruction
deq_i  in  1  decode consumes the queue head this cycle
iq_valid_o  out  1  queue non-empty
iq_pc_o  out  ADDR_W  PC of the queue head
iq_inst_o  out  INST_W  instruction at the queue head
iq_full_o  out  1  queue holds IQ_DEPTH entries

Behaviour:
- Reset (rst=1 at a clock edge, takes priority over rdy):
  - fetch_pc = RESET_PC.
  - All cache valid bits cleared.
  - Queue emptied: head, tail and count = 0.
  - State = IDLE.
  - mem_req_o = 0, mem_addr_o = 0.
  - Result: iq_valid_o = 0, iq_full_o = 0, iq_pc_o/iq_inst_o don't-care.
- rdy=0 and rst=0: no register changes. Outputs hold their values. A mem_done_i pulse in such a cycle is ignored; the memory controller honours the same rdy.
- Cache addressing: IDX = log2(ICACHE_LINES); index = pc[IDX+1:2]; tag = pc[ADDR_W-1:IDX+2]. pc[1:0] is always treated as 0.
- States:
  - IDLE: combinational lookup at fetch_pc.
    - Hit and queue not full: push {fetch_pc, data}; fetch_pc += 4 (wraps modulo 2^ADDR_W). The entry is visible on iq_* the next cycle, giving 1 instruction/cycle on hits.
    - Miss and queue not full: go to MISS; mem_req_o = 1 and mem_addr_o = fetch_pc from the next cycle.
    - Queue full: stall and hold fetch_pc.
  - MISS: mem_req_o and mem_addr_o are held stable until mem_done_i. A request is never withdrawn, and arbitration delay is absorbed by the controller.
    - On mem_done_i: write the cache line (valid, tag, data); push {mem_addr_o, mem_data_i}. A slot is guaranteed because the queue was not full on entry and only dequeues occur meanwhile. Then fetch_pc += 4, mem_req_o = 0, go to IDLE.
  - ABORT: entered when flush_i=1 while in MISS without a same-cycle mem_done_i. Keeps the request asserted. On mem_done_i: fill the cache, do not push, drop mem_req_o, go to IDLE.
- Flush (flush_i=1):
  - Queue cleared and fetch_pc = flush_pc_i.
  - No push occurs this cycle, and deq_i is ignored.
  - From IDLE: stay in IDLE; fetching of flush_pc_i starts next cycle.
  - From MISS with same-cycle mem_done_i: cache filled, no push, go to IDLE.
  - From MISS without mem_done_i: go to ABORT.
  - In ABORT: update fetch_pc again and stay in ABORT.
- Queue: circular buffer with head/tail pointers and a count (0..IQ_DEPTH).
  - Pop when deq_i=1 and iq_valid_o=1. deq_i on an empty queue is ignored.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push is gated on the registered count, so no push occurs at full even if a pop happens the same cycle.
  - iq_pc_o and iq_inst_o are read combinationally from the head entry.
- The cache has no write or invalidate path other than miss fills; self-modifying code is unsupported.

Test Plan:
- Cold start: reset then release, RESET_PC=0. Required: mem_req_o=1, mem_addr_o=0x0 on the second cycle. After mem_done_i with data 0x00500093: iq_valid_o=1, iq_pc_o=0x0, iq_inst_o=0x00500093, and the next request is to 0x4.
- Hit stream: after filling 0x0–0x1C, flush to 0x0 with deq_i=1 every cycle. Required: 8 consecutive cycles with iq_valid_o=1, PCs 0x0,0x4,…,0x1C, and mem_req_o=0 throughout.
- Queue full: hits with deq_i=0 after 8 pushes. Required: iq_full_o=1 and fetch_pc held. One deq_i pulse gives one further push the following cycle, and the count returns to 8.
- Flush mid-miss: miss on 0x40, flush_i to 0x100 two cycles later, mem_done_i three cycles after that. Required: the 0x40 data is not queued and the line is valid (a later fetch of 0x40 hits). The next mem_addr_o is 0x100, and the queue is empty after the flush.
- Flush coincident with mem_done_i in MISS: required to go to IDLE with no push, fetch_pc=flush_pc_i, and no ABORT cycle.
- Conflict and rdy: 0x0 and 0x100 map to the same index with ICACHE_LINES=64; alternating fetches miss every time. Holding rdy=0 for 3 cycles mid-MISS keeps mem_req_o, mem_addr_o and the queue count unchanged.
